// File: rtl/whack_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | whack_game_ctrl                                                            |
// | Game-phase sequencer: mole selection from a Galois LFSR, score and lives.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module whack_game_ctrl #(
  parameter int                NUM_MOLES  = 4,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
  parameter int                UP_CYCLES  = 25_000_000,
  parameter int                GAP_CYCLES = 5_000_000,
  parameter int                SCORE_W    = 8,
  parameter int                LIVES      = 3,
  localparam int               c_IW       = (NUM_MOLES > 2) ? $clog2(NUM_MOLES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 hit_valid,
  input  logic [c_IW-1:0]      hit_idx,
  input  logic                 game_timeout,
  input  logic [LFSR_W-1:0]    seed,
  output logic [2:0]           state,
  output logic [NUM_MOLES-1:0] mole_onehot,
  output logic [c_IW-1:0]      mole_idx,
  output logic                 game_start,
  output logic                 draw_enable,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [3:0]           lives,
  output logic                 game_over
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_ARM  = 3'd1;
  localparam logic [2:0] c_UP   = 3'd2;
  localparam logic [2:0] c_HIT  = 3'd3;
  localparam logic [2:0] c_OVER = 3'd4;

  localparam int               c_CNT_MAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int               c_CW      = $clog2(c_CNT_MAX + 1);
  localparam logic [SCORE_W-1:0] c_SAT   = '1;
  localparam logic [3:0]       c_LIVES   = 4'(LIVES);

  logic [2:0]           r_state;
  logic [2:0]           w_state_nx;
  logic                 r_prev_start;
  logic [c_CW-1:0]      r_cnt;
  logic [LFSR_W-1:0]    r_lfsr;
  logic [LFSR_W-1:0]    w_lfsr_nx;

  logic                 w_start_edge;
  logic                 w_hit_ok;
  logic                 w_hit_bad;
  logic                 w_up_done;
  logic                 w_gap_done;
  logic                 w_lose_life;
  logic                 w_last_life;
  logic [c_IW-1:0]      w_cand_raw;
  logic [c_IW-1:0]      w_cand;
  logic [c_IW-1:0]      w_mole_sel;

  logic [c_IW-1:0]      w_mole_nx;
  logic [NUM_MOLES-1:0] w_onehot_nx;
  logic [SCORE_W-1:0]   w_score_nx;
  logic [SCORE_W-1:0]   w_misses_nx;
  logic [3:0]           w_lives_nx;
  logic                 w_game_start_nx;

  assign state        = r_state;
  assign w_start_edge = start & ~r_prev_start;
  assign w_hit_ok     = hit_valid && (hit_idx == mole_idx);
  assign w_hit_bad    = hit_valid && (hit_idx != mole_idx);
  assign w_up_done    = (r_cnt == c_CW'(UP_CYCLES - 1));
  assign w_gap_done   = (r_cnt == c_CW'(GAP_CYCLES - 1));
  // A wrong hit coinciding with expiry costs only one miss and one life.
  assign w_lose_life  = w_hit_bad || w_up_done;
  assign w_last_life  = (lives <= 4'd1);

  // Fold the raw LFSR slice into range, then step past the previous mole.
  assign w_cand_raw = r_lfsr[c_IW-1:0];
  assign w_cand     = ({1'b0, w_cand_raw} >= (c_IW+1)'(NUM_MOLES))
                    ? w_cand_raw - c_IW'(NUM_MOLES) : w_cand_raw;
  assign w_mole_sel = (w_cand != mole_idx) ? w_cand
                    : (w_cand == c_IW'(NUM_MOLES - 1)) ? '0 : w_cand + c_IW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      c_IDLE: if (w_start_edge) w_state_nx = c_ARM;
      c_ARM: begin
        if (game_timeout)    w_state_nx = c_OVER;
        else if (w_gap_done) w_state_nx = c_UP;
      end
      c_UP: begin
        if (game_timeout)  w_state_nx = c_OVER;
        else if (w_hit_ok) w_state_nx = c_HIT;
        else if (w_lose_life) begin
          if (w_last_life)    w_state_nx = c_OVER;
          else if (w_up_done) w_state_nx = c_ARM;
        end
      end
      c_HIT:  w_state_nx = game_timeout ? c_OVER : c_ARM;
      c_OVER: if (w_start_edge) w_state_nx = c_IDLE;
      default: w_state_nx = c_IDLE;
    endcase
  end

  always_comb begin
    w_score_nx      = score;
    w_misses_nx     = misses;
    w_lives_nx      = lives;
    w_mole_nx       = mole_idx;
    w_game_start_nx = 1'b0;
    w_lfsr_nx       = r_lfsr;
    if (r_state != c_IDLE) begin
      w_lfsr_nx = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    end
    case (r_state)
      c_IDLE: begin
        if (w_start_edge) begin
          w_lfsr_nx       = (seed == '0) ? LFSR_W'(1) : seed;
          w_score_nx      = '0;
          w_misses_nx     = '0;
          w_lives_nx      = c_LIVES;
          w_game_start_nx = 1'b1;
        end
      end
      c_ARM: if (!game_timeout && w_gap_done) w_mole_nx = w_mole_sel;
      c_UP: begin
        if (!game_timeout) begin
          if (w_hit_ok) begin
            if (score != c_SAT) w_score_nx = score + SCORE_W'(1);
          end else if (w_lose_life) begin
            if (misses != c_SAT) w_misses_nx = misses + SCORE_W'(1);
            if (lives != 4'd0)   w_lives_nx  = lives - 4'd1;
          end
        end
      end
      default: ;
    endcase
    w_onehot_nx = '0;
    if (w_state_nx == c_UP) w_onehot_nx = NUM_MOLES'(1) << w_mole_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_start <= 1'b0;
      r_cnt        <= '0;
      r_lfsr       <= LFSR_W'(1);
      mole_onehot  <= '0;
      mole_idx     <= '0;
      game_start   <= 1'b0;
      draw_enable  <= 1'b0;
      score        <= '0;
      misses       <= '0;
      lives        <= c_LIVES;
      game_over    <= 1'b0;
    end else begin
      r_prev_start <= start;
      if (w_state_nx != r_state) begin
        r_cnt <= '0;
      end else if (r_state == c_ARM || r_state == c_UP) begin
        r_cnt <= r_cnt + c_CW'(1);
      end
      r_lfsr      <= w_lfsr_nx;
      mole_onehot <= w_onehot_nx;
      mole_idx    <= w_mole_nx;
      game_start  <= w_game_start_nx;
      draw_enable <= 1'b1;
      score       <= w_score_nx;
      misses      <= w_misses_nx;
      lives       <= w_lives_nx;
      game_over   <= (w_state_nx == c_OVER);
    end
  end

endmodule
`default_nettype wire

// File: doc/whack_game_ctrl.md
# whack_game_ctrl

Parametrised game-state controller for the whack-a-mole game: it sequences idle, mole-arm gap, mole-up window, hit acknowledge and game-over phases for `NUM_MOLES` holes. Mole selection comes from an internal seeded Galois LFSR with a no-immediate-repeat rule. It keeps score, miss count and remaining lives. It sits between the button/keypad input conditioning, the game timer datapath and the VGA draw logic, and adds per-mole up-time windows, lives and scoring.

## Interface
Parameters:
- `NUM_MOLES`, 4, number of holes; legal range 2..16.
- `LFSR_W`, 16, LFSR width.
- `LFSR_TAPS`, 16'hB400, Galois feedback mask; `LFSR_W` bits wide.
- `UP_CYCLES`, 25_000_000, cycles a mole stays up; must be at least 2.
- `GAP_CYCLES`, 5_000_000, cycles between moles; must be at least 1.
- `SCORE_W`, 8, width of the score and miss counters.
- `LIVES`, 3, lives per game; legal range 1..15.

Ports (IW = max(1, clog2(NUM_MOLES))):
- `clk` in 1: 50 MHz clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: start/restart button, already synchronised; the block acts on its rising edge.
- `hit_valid` in 1: one-cycle pulse, the player struck a hole.
- `hit_idx` in IW: hole struck; sampled only when `hit_valid`=1.
- `game_timeout` in 1: level from the game timer; the game time has expired.
- `seed` in LFSR_W: LFSR seed, loaded on game start.
- `state` out 3: IDLE=0, ARM=1, UP=2, HIT=3, OVER=4.
- `mole_onehot` out NUM_MOLES: the mole currently up; all zero outside UP.
- `mole_idx` out IW: index of the current or last mole.
- `game_start` out 1: one-cycle pulse on the IDLE→ARM transition; the game timer restarts on it.
- `draw_enable` out 1: high in every state once out of reset.
- `score` out SCORE_W: correct hits, saturating.
- `misses` out SCORE_W: wrong hits plus expired moles, saturating.
- `lives` out 4: remaining lives.
- `game_over` out 1: high while in OVER.

## Operation
- All outputs are registered.
- Reset values: `state`=IDLE, `mole_onehot`=0, `mole_idx`=0, `game_start`=0, `draw_enable`=0, `score`=0, `misses`=0, `lives`=LIVES, `game_over`=0, LFSR=1, prev-start=0.
- `start` edge detect: `start` & ~prev-start, where prev-start is registered.

State transitions:
- IDLE:
  - On a start edge: go to ARM.
  - Load the LFSR with `seed`; a zero seed loads 1.
  - Clear `score` and `misses`, set `lives`=LIVES, pulse `game_start`.
- ARM:
  - Gap counter runs for GAP_CYCLES cycles, then the controller goes to UP.
  - On entry to UP, select the mole: cand = LFSR[IW-1:0].
  - If cand ≥ NUM_MOLES, subtract NUM_MOLES.
  - If cand equals the previous `mole_idx`, use (cand+1) mod NUM_MOLES.
  - Register the result into `mole_idx` and `mole_onehot`.
- UP (up counter starts at 0 on entry):
  - `hit_valid` with `hit_idx`==`mole_idx`: go to HIT, `score`+1.
  - `hit_valid` with a wrong index: `misses`+1, `lives`-1; stay in UP, up counter not reset.
  - Up counter reaches UP_CYCLES-1 with no hit: `misses`+1, `lives`-1, go to ARM.
  - A `lives` decrement that reaches 0 goes to OVER instead of staying in UP or going to ARM.
- HIT: lasts exactly 1 cycle, then ARM.
- OVER:
  - `mole_onehot`=0 and `game_over`=1.
  - On a start edge: go to IDLE. A second start edge is needed to begin a new game.
- The LFSR advances every cycle outside IDLE: shift right, XOR `LFSR_TAPS` when the LSB is 1.

Priority within a cycle, highest first:
1. `game_timeout` in ARM, UP or HIT → OVER; no score or life change that cycle.
2. Correct hit.
3. Wrong hit and up-expiry in the same cycle: a single miss and a single life lost, go to ARM.

Other rules:
- `hit_valid` outside UP is ignored.
- A `start` edge in ARM, UP or HIT is ignored.
- `score` and `misses` saturate at all ones; `lives` never goes below 0.
- `draw_enable` becomes 1 on the first clock after reset deasserts and stays 1.

## Timing
- A start edge at cycle t (IDLE): `state`=ARM and `game_start`=1 at t+1; `game_start`=0 at t+2.
- ARM entered at cycle a: `state`=UP and `mole_onehot` valid at a+GAP_CYCLES.
- Correct hit at cycle h: HIT and the new `score` at h+1, ARM at h+2.
- No hit: UP lasts exactly UP_CYCLES cycles, then ARM.
- `game_timeout` at cycle g: OVER at g+1.
- Reset asserted mid-game: all outputs return to their reset values immediately (asynchronous reset).

## Test plan
- Reset low, then high; start edge; NUM_MOLES=4, GAP_CYCLES=3, UP_CYCLES=5 → `game_start` high 1 cycle; UP after 3 ARM cycles; `mole_onehot` has exactly one bit set.
- In UP, `hit_valid` with the correct `hit_idx` → HIT for 1 cycle, `score`=1, then ARM; the next mole index differs from the previous one.
- Never hit, LIVES=3 → three UP windows of 5 cycles each; `misses`=3, `lives`=0, OVER; `mole_onehot`=0.
- `game_timeout` asserted in the same cycle as a correct hit → OVER next cycle, `score` unchanged.
- NUM_MOLES=5, seed=0, run 1000 moles → every index is 0..4, no back-to-back repeats, all five indices appear.
- SCORE_W=2, 5 correct hits → `score` saturates at 3; reset asserted mid-UP → all outputs return to reset values with no clock edge.
